// File: rtl/lcd_bus_reader.sv
// Read-side engine for an HD44780 16x2 LCD bus: arbitrates for the bus, runs RS/RW/EN read
// cycles, samples status or DDRAM data, and can poll the busy flag until it clears.
module lcd_bus_reader #(
  parameter int T_AS     = 3,
  parameter int T_PW     = 13,
  parameter int T_LO     = 13,
  parameter int POLL_MAX = 4096
) (
  input  logic       CLK_50,
  input  logic       RST,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       poll,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       bf,
  output logic [6:0] addr,
  output logic       timeout,
  output logic       bus_req,
  input  logic       bus_gnt,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  localparam int TW = 8;
  localparam logic [TW-1:0] AS_LAST = TW'(T_AS - 1);
  localparam logic [TW-1:0] PW_LAST = TW'(T_PW - 1);
  localparam logic [TW-1:0] LO_LAST = TW'(T_LO - 1);
  localparam logic [12:0]   PMAX    = 13'(POLL_MAX);
  localparam logic [12:0]   RD_SAT  = 13'h1FFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GNT = 3'd1,
    SETUP    = 3'd2,
    EN_HI    = 3'd3,
    EN_LO    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t          state_reg;
  logic [TW-1:0]   timer_reg;
  logic [12:0]     reads_reg;
  logic [7:0]      cap_reg;
  logic            rs_reg;
  logic            poll_reg;

  // Outputs are registered: each transition loads the values the next state presents.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      reads_reg <= '0;
      cap_reg   <= '0;
      rs_reg    <= 1'b0;
      poll_reg  <= 1'b0;
      rd_ready  <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      bf        <= 1'b0;
      addr      <= '0;
      timeout   <= 1'b0;
      bus_req   <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_RW    <= 1'b0;
      LCD_EN    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rd_req) begin
            rs_reg    <= rd_rs;
            poll_reg  <= poll & ~rd_rs;
            reads_reg <= '0;
            rd_ready  <= 1'b0;
            bus_req   <= 1'b1;
            state_reg <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (bus_gnt) begin
            timer_reg <= '0;
            LCD_RW    <= 1'b1;
            LCD_RS    <= rs_reg;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          if (timer_reg == AS_LAST) begin
            timer_reg <= '0;
            LCD_EN    <= 1'b1;
            state_reg <= EN_HI;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        EN_HI: begin
          if (timer_reg == PW_LAST) begin
            timer_reg <= '0;
            LCD_EN    <= 1'b0;
            cap_reg   <= LCD_DATA_IN;
            if (reads_reg != RD_SAT) reads_reg <= reads_reg + 1'b1;
            state_reg <= EN_LO;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        EN_LO: begin
          if (timer_reg == LO_LAST) begin
            timer_reg <= '0;
            if (poll_reg && cap_reg[7] && (reads_reg < PMAX)) begin
              state_reg <= SETUP;
            end else begin
              // A poll only reaches here with BF still set once the read budget is spent.
              rd_valid  <= 1'b1;
              rd_data   <= cap_reg;
              bf        <= rs_reg ? 1'b0 : cap_reg[7];
              addr      <= rs_reg ? 7'd0 : cap_reg[6:0];
              timeout   <= poll_reg & cap_reg[7];
              LCD_RW    <= 1'b0;
              LCD_RS    <= 1'b0;
              bus_req   <= 1'b0;
              state_reg <= DONE;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        DONE: begin
          rd_ready  <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          rd_ready  <= 1'b1;
          bus_req   <= 1'b0;
          LCD_EN    <= 1'b0;
          LCD_RW    <= 1'b0;
          LCD_RS    <= 1'b0;
        end
      endcase
    end
  end

endmodule
